// File: rtl/datapath_if.sv
// rtl/datapath_if.sv - control, memory-data and bus signals of the single-bus datapath slice
interface datapath_if;
  logic [31:0] MData_In;
  logic        Read;
  logic        MDR_In;
  logic        MAR_In;
  logic        PC_In;
  logic        IR_In;
  logic        Y_In;
  logic        Z_In;
  logic        R2_In;
  logic        R5_In;
  logic        MDR_Out;
  logic        PC_Out;
  logic        ZLO_Out;
  logic        R2_Out;
  logic        IncPC;
  logic [4:0]  CONTROL;
  logic [31:0] BusMux_Out;

  // master: the control-step sequencer; slave: the datapath
  modport master (
    output MData_In, Read,
    output MDR_In, MAR_In, PC_In, IR_In, Y_In, Z_In, R2_In, R5_In,
    output MDR_Out, PC_Out, ZLO_Out, R2_Out,
    output IncPC, CONTROL,
    input  BusMux_Out
  );

  modport slave (
    input  MData_In, Read,
    input  MDR_In, MAR_In, PC_In, IR_In, Y_In, Z_In, R2_In, R5_In,
    input  MDR_Out, PC_Out, ZLO_Out, R2_Out,
    input  IncPC, CONTROL,
    output BusMux_Out
  );
endinterface

// File: rtl/datapath.sv
// rtl/datapath.sv - single-bus 32-bit datapath: PC/IR/MAR/MDR/Y/Z/R2/R5 fed from one bus, ALU Y op bus into Z
module datapath (
  input  logic      Clock,
  input  logic      Clear,
  datapath_if.slave bus_if
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_OR   = 5'b00011,
    OP_SHR  = 5'b00100,
    OP_SHL  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_NEG  = 5'b01001,
    OP_NOT  = 5'b01010
  } alu_op_e;

  logic [31:0] pc_q,  pc_d;
  logic [31:0] ir_q,  ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q,   y_d;
  logic [31:0] z_q,   z_d;
  logic [31:0] r2_q,  r2_d;
  logic [31:0] r5_q,  r5_d;

  logic [31:0] bus;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  sh_amt;
  logic [5:0]  sh_inv;
  logic [31:0] alu_res;

  // Fixed-priority bus source; no request leaves the bus at zero
  always_comb begin
    bus = 32'h0;
    if (bus_if.ZLO_Out)
      bus = z_q;
    else if (bus_if.MDR_Out)
      bus = mdr_q;
    else if (bus_if.PC_Out)
      bus = pc_q;
    else if (bus_if.R2_Out)
      bus = r2_q;
  end

  assign bus_if.BusMux_Out = bus;

  // Rotates use a complementary shift; sh_amt = 0 gives a 32-bit shift, which yields 0
  always_comb begin
    alu_a   = y_q;
    alu_b   = bus;
    sh_amt  = alu_b[4:0];
    sh_inv  = 6'd32 - {1'b0, sh_amt};
    alu_res = alu_b;
    if (bus_if.IncPC) begin
      alu_res = alu_b + 32'd1;
    end else begin
      case (bus_if.CONTROL)
        OP_ADD:  alu_res = alu_a + alu_b;
        OP_SUB:  alu_res = alu_a - alu_b;
        OP_AND:  alu_res = alu_a & alu_b;
        OP_OR:   alu_res = alu_a | alu_b;
        OP_SHR:  alu_res = alu_a >> sh_amt;
        OP_SHL:  alu_res = alu_a << sh_amt;
        OP_SHRA: alu_res = $unsigned($signed(alu_a) >>> sh_amt);
        OP_ROR:  alu_res = (alu_a >> sh_amt) | (alu_a << sh_inv);
        OP_ROL:  alu_res = (alu_a << sh_amt) | (alu_a >> sh_inv);
        OP_NEG:  alu_res = 32'd0 - alu_b;
        OP_NOT:  alu_res = ~alu_b;
        default: alu_res = alu_b;
      endcase
    end
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    z_d   = z_q;
    r2_d  = r2_q;
    r5_d  = r5_q;
    if (bus_if.PC_In)  pc_d  = bus;
    if (bus_if.IR_In)  ir_d  = bus;
    if (bus_if.MAR_In) mar_d = bus;
    if (bus_if.MDR_In) mdr_d = bus_if.Read ? bus_if.MData_In : bus;
    if (bus_if.Y_In)   y_d   = bus;
    if (bus_if.Z_In)   z_d   = alu_res;
    if (bus_if.R2_In)  r2_d  = bus;
    if (bus_if.R5_In)  r5_d  = bus;
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      pc_q  <= 32'h0;
      ir_q  <= 32'h0;
      mar_q <= 32'h0;
      mdr_q <= 32'h0;
      y_q   <= 32'h0;
      z_q   <= 32'h0;
      r2_q  <= 32'h0;
      r5_q  <= 32'h0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      r2_q  <= r2_d;
      r5_q  <= r5_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - directed self-checking bench for the datapath slice
module tb_datapath;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;

  datapath_if dp_if ();

  datapath dut (
    .Clock  (clk),
    .Clear  (clr),
    .bus_if (dp_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    dp_if.MData_In = 32'h0;
    dp_if.Read     = 1'b0;
    dp_if.MDR_In   = 1'b0;
    dp_if.MAR_In   = 1'b0;
    dp_if.PC_In    = 1'b0;
    dp_if.IR_In    = 1'b0;
    dp_if.Y_In     = 1'b0;
    dp_if.Z_In     = 1'b0;
    dp_if.R2_In    = 1'b0;
    dp_if.R5_In    = 1'b0;
    dp_if.MDR_Out  = 1'b0;
    dp_if.PC_Out   = 1'b0;
    dp_if.ZLO_Out  = 1'b0;
    dp_if.R2_Out   = 1'b0;
    dp_if.IncPC    = 1'b0;
    dp_if.CONTROL  = 5'b0;
  endtask

  // one rising edge, then return 1 time unit after it with controls idle
  task automatic cyc();
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    dp_if.MData_In = v;
    dp_if.Read     = 1'b1;
    dp_if.MDR_In   = 1'b1;
    cyc();
  endtask

  task automatic load_y(input logic [31:0] v);
    load_mdr(v);
    dp_if.MDR_Out = 1'b1;
    dp_if.Y_In    = 1'b1;
    cyc();
  endtask

  // Z <= Y op b with b supplied from MDR, then read Z back over the bus
  task automatic alu_check(input string tag, input logic [4:0] op, input logic [31:0] b,
                           input logic [31:0] exp);
    load_mdr(b);
    dp_if.MDR_Out = 1'b1;
    dp_if.CONTROL = op;
    dp_if.Z_In    = 1'b1;
    cyc();
    dp_if.ZLO_Out = 1'b1;
    #1;
    check_val(tag, dp_if.BusMux_Out, exp);
    set_idle();
  endtask

  typedef struct {
    string       tag;
    logic [4:0]  op;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[10];

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{"add",      5'b00000, 32'h11111111, 32'h23456789};
    vecs[1] = '{"sub",      5'b00001, 32'h00000678, 32'h12345000};
    vecs[2] = '{"and",      5'b00010, 32'h0F0F0F0F, 32'h02040608};
    vecs[3] = '{"or",       5'b00011, 32'hF0000000, 32'hF2345678};
    vecs[4] = '{"ror4",     5'b00111, 32'h00000004, 32'h81234567};
    vecs[5] = '{"rol8",     5'b01000, 32'h00000008, 32'h34567812};
    vecs[6] = '{"neg",      5'b01001, 32'h00000001, 32'hFFFFFFFF};
    vecs[7] = '{"not",      5'b01010, 32'h0000FFFF, 32'hFFFF0000};
    vecs[8] = '{"pass",     5'b11111, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[9] = '{"shl_mask", 5'b00101, 32'h00000020, 32'h12345678};

    set_idle();
    clr = 1'b1;
    @(posedge clk);
    #1;
    // loads asserted during Clear must be ignored
    dp_if.MData_In = 32'h55;
    dp_if.Read     = 1'b1;
    dp_if.MDR_In   = 1'b1;
    dp_if.Z_In     = 1'b1;
    dp_if.IncPC    = 1'b1;
    cyc();
    clr = 1'b0;

    #1;
    check_val("idle_bus", dp_if.BusMux_Out, 32'h0);
    dp_if.PC_Out = 1'b1;
    #1;
    check_val("clr_pc", dp_if.BusMux_Out, 32'h0);
    cyc();
    dp_if.ZLO_Out = 1'b1;
    #1;
    check_val("clr_z", dp_if.BusMux_Out, 32'h0);
    cyc();
    dp_if.MDR_Out = 1'b1;
    #1;
    check_val("clr_mdr", dp_if.BusMux_Out, 32'h0);
    cyc();

    // register loads through MDR
    load_mdr(32'h22);
    dp_if.MDR_Out = 1'b1;
    dp_if.R2_In   = 1'b1;
    #1;
    check_val("mdr_22", dp_if.BusMux_Out, 32'h22);
    cyc();
    dp_if.R2_Out = 1'b1;
    #1;
    check_val("r2_22", dp_if.BusMux_Out, 32'h22);
    cyc();
    load_mdr(32'h26);
    dp_if.MDR_Out = 1'b1;
    dp_if.R5_In   = 1'b1;
    cyc();
    check_val("r5_26", dut.r5_q, 32'h26);

    // fetch from reset
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    dp_if.PC_Out = 1'b1;
    dp_if.MAR_In = 1'b1;
    dp_if.IncPC  = 1'b1;
    dp_if.Z_In   = 1'b1;
    cyc();
    check_val("mar_0", dut.mar_q, 32'h0);
    dp_if.ZLO_Out  = 1'b1;
    dp_if.PC_In    = 1'b1;
    dp_if.Read     = 1'b1;
    dp_if.MDR_In   = 1'b1;
    dp_if.MData_In = 32'h4A920000;
    #1;
    check_val("fetch_z1", dp_if.BusMux_Out, 32'h1);
    cyc();
    dp_if.PC_Out = 1'b1;
    #1;
    check_val("fetch_pc", dp_if.BusMux_Out, 32'h1);
    set_idle();
    dp_if.MDR_Out = 1'b1;
    dp_if.IR_In   = 1'b1;
    #1;
    check_val("fetch_mdr", dp_if.BusMux_Out, 32'h4A920000);
    cyc();
    check_val("fetch_ir", dut.ir_q, 32'h4A920000);

    // PC_Out with PC_In in one cycle keeps PC
    dp_if.PC_Out = 1'b1;
    dp_if.PC_In  = 1'b1;
    cyc();
    dp_if.PC_Out = 1'b1;
    #1;
    check_val("pc_rw", dp_if.BusMux_Out, 32'h1);
    set_idle();

    // shifts on R2 = 0x22 by MDR = 4
    load_y(32'h22);
    alu_check("shl4", 5'b00101, 32'h4, 32'h220);
    dp_if.ZLO_Out = 1'b1;
    dp_if.R5_In   = 1'b1;
    cyc();
    check_val("r5_220", dut.r5_q, 32'h220);
    alu_check("shr4", 5'b00100, 32'h4, 32'h2);

    // shift by zero with an undriven bus
    dp_if.CONTROL = 5'b00101;
    dp_if.Z_In    = 1'b1;
    cyc();
    dp_if.ZLO_Out = 1'b1;
    #1;
    check_val("shl0", dp_if.BusMux_Out, 32'h22);
    set_idle();

    load_y(32'hFFFFFFFF);
    alu_check("add_wrap", 5'b00000, 32'h1, 32'h0);
    load_y(32'h80000000);
    alu_check("shra4", 5'b00110, 32'h4, 32'hF8000000);

    // bus priority: MDR holds 4, R2 holds 0x22, Z holds 0xF8000000
    dp_if.MDR_Out = 1'b1;
    dp_if.R2_Out  = 1'b1;
    #1;
    check_val("prio_mdr_r2", dp_if.BusMux_Out, 32'h4);
    dp_if.ZLO_Out = 1'b1;
    dp_if.PC_Out  = 1'b1;
    #1;
    check_val("prio_z", dp_if.BusMux_Out, 32'hF8000000);
    set_idle();

    load_y(32'h12345678);
    for (int i = 0; i < 10; i++)
      alu_check(vecs[i].tag, vecs[i].op, vecs[i].b, vecs[i].exp);

    // IncPC overrides CONTROL
    load_mdr(32'h5);
    dp_if.MDR_Out = 1'b1;
    dp_if.CONTROL = 5'b00001;
    dp_if.IncPC   = 1'b1;
    dp_if.Z_In    = 1'b1;
    cyc();
    dp_if.ZLO_Out = 1'b1;
    dp_if.IncPC   = 1'b1;
    dp_if.Z_In    = 1'b1;
    #1;
    check_val("incpc", dp_if.BusMux_Out, 32'h6);
    cyc();
    dp_if.ZLO_Out = 1'b1;
    #1;
    check_val("z_rw", dp_if.BusMux_Out, 32'h7);
    set_idle();

    // several loads in one cycle share the bus value
    dp_if.ZLO_Out = 1'b1;
    dp_if.R2_In   = 1'b1;
    dp_if.PC_In   = 1'b1;
    dp_if.Read    = 1'b0;
    dp_if.MDR_In  = 1'b1;
    cyc();
    check_val("multi_r2", dut.r2_q, 32'h7);
    check_val("multi_pc", dut.pc_q, 32'h7);
    check_val("multi_mdr", dut.mdr_q, 32'h7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Single-bus 32-bit processor datapath slice, used to exercise instruction fetch and ALU/shift operations. It contains PC, IR, MAR, MDR, Y, Z and general registers R2 and R5, all fed from one shared bus, plus an ALU computing Y op Bus into Z. A control-step sequencer outside this block drives every enable; the block makes no sequencing decisions.

## Interface
Parameters: none.

- Clock  in  1  sole clock; all registers update on rising edge
- Clear  in  1  reset; synchronous, active-high; zeroes every register
- MData_In  in  32  memory read data into MDR
- Read  in  1  MDR source select: 1 = MData_In, 0 = bus
- MDR_In, MAR_In, PC_In, IR_In, Y_In, Z_In, R2_In, R5_In  in  1 each  register load enables
- MDR_Out, PC_Out, ZLO_Out, R2_Out  in  1 each  bus drive requests
- IncPC  in  1  forces ALU to compute Bus+1, overriding CONTROL
- CONTROL  in  5  ALU operation select
- BusMux_Out  out  32  current bus value, combinational

## Operation
- Bus: combinational priority mux, ZLO_Out > MDR_Out > PC_Out > R2_Out; no request asserted -> bus = 0.
- Registers (32-bit, all reset 0): PC, IR, MAR, MDR, Y, Z, R2, R5. Each loads on rising edge when its enable is high. Source is the bus for every register except MDR (MData_In when Read=1, else bus) and Z (ALU result).
- MAR and IR are internal only; no output port.
- ALU: A = Y, B = bus. Result is written to Z only when Z_In=1.
- IncPC=1 -> result = B + 1, whatever CONTROL holds.
- CONTROL encoding (IncPC=0):
  - 00000 ADD A+B
  - 00001 SUB A-B
  - 00010 AND
  - 00011 OR
  - 00100 SHR: logical right shift of A by B[4:0]
  - 00101 SHL: left shift of A by B[4:0]
  - 00110 SHRA: arithmetic right shift of A by B[4:0]
  - 00111 ROR: rotate A right by B[4:0]
  - 01000 ROL: rotate A left by B[4:0]
  - 01001 NEG: -B
  - 01010 NOT: ~B
  - any other code: pass B
- Arithmetic is modulo 2^32; carry and overflow are discarded. Shift amount 0 leaves A unchanged.

## Timing
- Clear=1 at a rising edge: all registers become 0 and loads in that cycle are ignored. BusMux_Out is then 0 unless a drive request is high; a request of ZLO_Out, MDR_Out, PC_Out or R2_Out then drives 0.
- Load latency is 1 edge. A value placed on the bus in cycle n is visible from the target register in cycle n+1.
- Read-and-write of the same register in one cycle is legal. Example: ZLO_Out with Z_In, or PC_Out with PC_In. The bus carries the old value and the register captures the new value at the edge.
- Several load enables in one cycle all capture the same bus value.
- ALU path is purely combinational. Z captures the result at the edge where Z_In=1.

## Test plan
- Clear: pulse Clear one cycle, then assert PC_Out, later ZLO_Out, later MDR_Out -> bus reads 0 each time.
- Register load: MData_In=0x22, Read=1, MDR_In=1 for one edge; next cycle MDR_Out=1, R2_In=1 -> R2_Out then drives 0x22. Repeat with 0x26 into R5.
- Fetch:
  - Step 1, from reset: PC_Out, MAR_In, IncPC, Z_In -> Z = 1.
  - Step 2: ZLO_Out, PC_In, Read, MDR_In with MData_In=0x4A920000 -> PC = 1, MDR = 0x4A920000.
  - Step 3: MDR_Out, IR_In -> bus shows 0x4A920000.
- Shift left: R2=0x22 and R2_Out+Y_In. Then load MDR=4 and apply MDR_Out, CONTROL=00101, Z_In. Then ZLO_Out+R5_In -> R5 = 0x220, and ZLO_Out shows 0x220. CONTROL=00100 with the same operands -> 0x2.
- Shift by zero: Y=0x22, bus 0 (no drive request), CONTROL=00101, Z_In -> Z = 0x22.
- Arithmetic and priority:
  - Y=0xFFFFFFFF, B=1, ADD -> Z = 0.
  - Y=0x80000000, B=4, SHRA -> Z = 0xF8000000.
  - MDR_Out and R2_Out asserted together -> bus carries MDR.
